// File: rtl/fpu_round_pkg.sv
// Shared widths, stage-1 bundle and helpers for the
// rounder's normalization shifter.
package fpu_round_pkg;

  localparam int SIG_W = 58;
  localparam int EXP_W = 13;
  localparam int MAG_W = EXP_W + 1;
  localparam int CRS_W = 6;
  localparam int FIN_W = 3;

  typedef struct packed {
    logic [SIG_W-1:0] coarse;
    logic [FIN_W-1:0] fine;
    logic             dir;
    logic             sat;
    logic             st;
    logic [EXP_W-1:0] en;
    logic             db;
    logic             tiny;
  } s1_t;

  // One extra bit so that the most negative distance has a magnitude
  function automatic logic [MAG_W-1:0] abs_sh(
    input logic [EXP_W-1:0] sh
  );
    logic [MAG_W-1:0] ext;
    ext = {sh[EXP_W-1], sh};
    return sh[EXP_W-1] ? (~ext + 1'b1) : ext;
  endfunction

endpackage

// File: rtl/norm_shift_pipe_sticky_shr.sv
// Logical right shift that also reports whether any
// set bit fell off the low end.
module sticky_shr #(
  parameter int W  = 58,
  parameter int AW = 6
) (
  input  logic [W-1:0]  data,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  shifted,
  output logic          sticky
);

  logic [W-1:0] mask;

  always_comb begin
    mask    = ~({W{1'b1}} << amt);
    shifted = data >> amt;
    sticky  = |(data & mask);
  end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalization shifter: coarse byte-step
// shift in stage 1, fine bit shift plus sticky in stage 2.
module norm_shift_pipe
  import fpu_round_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] fr,
  input  logic [EXP_W-1:0] er,
  input  logic [EXP_W-1:0] sh,
  input  logic             db,
  input  logic             tiny,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] fn,
  output logic [EXP_W-1:0] en,
  output logic             st,
  output logic             db_o,
  output logic             tiny_o
);

  logic             s1_valid_q;
  logic             s1_valid_d;
  logic             s2_valid_q;
  logic             s2_valid_d;
  s1_t              s1_q;
  s1_t              s1_d;
  logic [SIG_W-1:0] fn_q;
  logic [SIG_W-1:0] fn_d;
  logic [EXP_W-1:0] en_q;
  logic [EXP_W-1:0] en_d;
  logic             st_q;
  logic             st_d;
  logic             db_q;
  logic             db_d;
  logic             tiny_q;
  logic             tiny_d;

  logic             s1_adv;
  logic             s1_load;
  logic             s2_load;

  logic             dir;
  logic [MAG_W-1:0] mag;
  logic             sat;
  logic [CRS_W-1:0] crs_amt;
  logic [SIG_W-1:0] crs_l;
  logic [SIG_W-1:0] crs_r;
  logic             crs_s;

  logic [SIG_W-1:0] fin_l;
  logic [SIG_W-1:0] fin_r;
  logic             fin_s;
  logic [SIG_W-1:0] fn_res;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign s1_load  = in_valid && in_ready && !flush;
  assign s2_load  = s1_valid_q && s1_adv && !flush;

  assign out_valid = s2_valid_q;
  assign fn        = fn_q;
  assign en        = en_q;
  assign st        = st_q;
  assign db_o      = db_q;
  assign tiny_o    = tiny_q;

  always_comb begin
    dir     = sh[EXP_W-1];
    mag     = abs_sh(sh);
    sat     = mag >= MAG_W'(SIG_W);
    crs_amt = {mag[5:3], 3'b000};
    crs_l   = fr << crs_amt;
  end

  sticky_shr #(
    .W  (SIG_W),
    .AW (CRS_W)
  ) u_crs (
    .data    (fr),
    .amt     (crs_amt),
    .shifted (crs_r),
    .sticky  (crs_s)
  );

  always_comb begin
    s1_d = s1_q;
    if (s1_load) begin
      s1_d.coarse = sat ? '0 : (dir ? crs_r : crs_l);
      s1_d.fine   = mag[FIN_W-1:0];
      s1_d.dir    = dir;
      s1_d.sat    = sat;
      s1_d.st     = dir & (sat ? |fr : crs_s);
      s1_d.en     = er - sh;
      s1_d.db     = db;
      s1_d.tiny   = tiny;
    end
  end

  assign fin_l = s1_q.coarse << s1_q.fine;

  sticky_shr #(
    .W  (SIG_W),
    .AW (FIN_W)
  ) u_fin (
    .data    (s1_q.coarse),
    .amt     (s1_q.fine),
    .shifted (fin_r),
    .sticky  (fin_s)
  );

  always_comb begin
    fn_res = '0;
    unique case (1'b1)
      s1_q.sat:               fn_res = '0;
      !s1_q.sat && s1_q.dir:  fn_res = fin_r;
      !s1_q.sat && !s1_q.dir: fn_res = fin_l;
      default:                fn_res = '0;
    endcase
  end

  always_comb begin
    fn_d   = fn_q;
    en_d   = en_q;
    st_d   = st_q;
    db_d   = db_q;
    tiny_d = tiny_q;
    if (s2_load) begin
      fn_d   = fn_res;
      en_d   = s1_q.en;
      st_d   = s1_q.st | (s1_q.dir & !s1_q.sat & fin_s);
      db_d   = s1_q.db;
      tiny_d = s1_q.tiny;
    end
  end

  // flush only kills the valid bits; data regs keep their contents
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_ready) s1_valid_d = in_valid;
      if (s1_adv)   s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      fn_q       <= '0;
      en_q       <= '0;
      st_q       <= 1'b0;
      db_q       <= 1'b0;
      tiny_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      fn_q       <= fn_d;
      en_q       <= en_d;
      st_q       <= st_d;
      db_q       <= db_d;
      tiny_q     <= tiny_d;
    end
  end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Scoreboard bench for norm_shift_pipe: a bit-loop
// reference model feeds an in-order expected queue.
module tb_norm_shift_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [57:0] fr;
  logic [12:0] er;
  logic [12:0] sh;
  logic        db;
  logic        tiny;
  logic        out_valid;
  logic        out_ready;
  logic [57:0] fn;
  logic [12:0] en;
  logic        st;
  logic        db_o;
  logic        tiny_o;

  norm_shift_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fr        (fr),
    .er        (er),
    .sh        (sh),
    .db        (db),
    .tiny      (tiny),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fn        (fn),
    .en        (en),
    .st        (st),
    .db_o      (db_o),
    .tiny_o    (tiny_o)
  );

  typedef struct packed {
    logic [57:0] fn;
    logic [12:0] en;
    logic        st;
    logic        db;
    logic        tiny;
  } res_t;

  res_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          acc;
  bit          hold;
  logic [57:0] hold_fn;
  logic [12:0] hold_en;
  logic        hold_st;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [57:0] f,
                                 input logic [12:0] e,
                                 input logic [12:0] s,
                                 input logic d, input logic t);
    res_t        r;
    logic [13:0] ms;
    int          m;
    r.st = 1'b0;
    ms = s[12] ? (14'd0 - {1'b1, s}) : {1'b0, s};
    m  = int'(ms);
    if (s[12]) begin
      if (m >= 58) begin
        r.fn = '0;
        r.st = |f;
      end else begin
        r.fn = f >> m;
        for (int i = 0; i < 58; i++)
          if (i < m && f[i]) r.st = 1'b1;
      end
    end else begin
      r.fn = (m >= 58) ? '0 : (f << m);
    end
    r.en   = e - s;
    r.db   = d;
    r.tiny = t;
    return r;
  endfunction

  // called at posedge+1; returns at the following posedge+1
  task automatic step(input logic v, input logic [57:0] f,
                      input logic [12:0] e, input logic [12:0] s,
                      input logic d, input logic t,
                      input logic o, input logic fl);
    res_t x;
    in_valid  = v;
    fr        = f;
    er        = e;
    sh        = s;
    db        = d;
    tiny      = t;
    out_ready = o;
    flush     = fl;
    #2;
    check("in_ready", in_ready, !(sb_q.size() >= 2 && !o));
    if (sb_q.size() == 0) check("idle_ov", out_valid, 0);
    if (sb_q.size() == 2) check("full_ov", out_valid, 1);
    if (out_valid && o && !fl) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        x = sb_q.pop_front();
        check("fn", fn, x.fn);
        check("en", en, x.en);
        check("st", st, x.st);
        check("db_o", db_o, x.db);
        check("tiny_o", tiny_o, x.tiny);
      end
    end
    hold    = out_valid && !o && !fl;
    hold_fn = fn;
    hold_en = en;
    hold_st = st;
    acc     = v && in_ready && !fl;
    if (acc) sb_q.push_back(model(f, e, s, d, t));
    if (fl) sb_q.delete();
    @(posedge clk);
    #1;
    if (hold) begin
      check("hold_ov", out_valid, 1);
      check("hold_fn", fn, hold_fn);
      check("hold_en", en, hold_en);
      check("hold_st", st, hold_st);
    end
  endtask

  task automatic idle(input logic o);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, o, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) idle(1'b1);
    check("drain", sb_q.size(), 0);
  endtask

  typedef struct packed {
    logic [57:0] f;
    logic [12:0] e;
    logic [12:0] s;
  } op_t;

  op_t dir_ops[$];

  initial begin
    logic [63:0] r64;
    int          k;
    int          idx;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    fr        = '0;
    er        = '0;
    sh        = '0;
    db        = 1'b0;
    tiny      = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ov", out_valid, 0);
    check("rst_ir", in_ready, 1);
    check("rst_fn", fn, 0);
    check("rst_en", en, 0);
    check("rst_st", st, 0);
    check("rst_db", db_o, 0);
    check("rst_tiny", tiny_o, 0);
    rst = 1'b0;
    idle(1'b1);

    // left by one, two-cycle latency
    step(1'b1, 58'h100_0000_0000_0000, 13'd5, 13'd1, 1'b1, 1'b0,
         1'b1, 1'b0);
    check("t1_lat1", out_valid, 0);
    idle(1'b1);
    check("t1_lat2", out_valid, 1);
    check("t1_fn", fn, 58'h200_0000_0000_0000);
    check("t1_en", en, 13'd4);
    check("t1_st", st, 0);
    drain();

    dir_ops.push_back('{58'h3, 13'h1C02, 13'h1FFF});
    dir_ops.push_back('{58'hF1, 13'd100, 13'h1FC6});
    dir_ops.push_back('{58'h0, 13'd100, 13'h1FC6});
    dir_ops.push_back('{58'h3FF_FFFF_FFFF_FFFF, 13'd7, 13'h1000});
    dir_ops.push_back('{58'h123_4567_89AB_CDEF, 13'd9, 13'd0});
    dir_ops.push_back('{58'h1, 13'd0, 13'd57});
    dir_ops.push_back('{58'h1, 13'd0, 13'd58});
    dir_ops.push_back('{58'h200_0000_0000_0000, 13'd0, 13'h1FC7});
    dir_ops.push_back('{58'h0FF, 13'd3, 13'h1FF8});
    dir_ops.push_back('{58'h100, 13'd3, 13'h1FF8});
    dir_ops.push_back('{58'h1, 13'h0FFF, 13'h1FFF});
    foreach (dir_ops[i])
      step(1'b1, dir_ops[i].f, dir_ops[i].e, dir_ops[i].s,
           i[0], i[1], 1'b1, 1'b0);
    drain();

    // four back-to-back ops, sink stalls three cycles after first result
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      step(idx < 4, 58'(64'h1111 << (idx * 4)), 13'(idx),
           13'(idx * 3 - 4), 1'b0, 1'b1,
           !(c >= 2 && c < 5), 1'b0);
      if (acc) idx++;
    end
    check("t4_sent", idx, 4);
    drain();

    // flush with two ops in flight
    step(1'b1, 58'hAB, 13'd1, 13'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 58'hCD, 13'd1, 13'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 58'hEF, 13'd1, 13'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    check("fl_ov", out_valid, 0);
    step(1'b1, 58'h5A5, 13'd20, 13'h1FFC, 1'b1, 1'b1, 1'b1, 1'b0);
    check("fl_lat1", out_valid, 0);
    idle(1'b1);
    check("fl_lat2", out_valid, 1);
    drain();

    // async reset mid-stream
    step(1'b1, 58'h77, 13'd2, 13'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 58'h99, 13'd2, 13'h1FFE, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("ar_ov", out_valid, 0);
    check("ar_ir", in_ready, 1);
    check("ar_fn", fn, 0);
    check("ar_en", en, 0);
    check("ar_st", st, 0);
    check("ar_db", db_o, 0);
    check("ar_tiny", tiny_o, 0);
    #1;
    rst = 1'b0;
    sb_q.delete();
    idle(1'b1);
    idle(1'b1);
    check("ar_quiet", out_valid, 0);

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      r64 = {$urandom(), $urandom()};
      r64 = r64 >> $urandom_range(0, 60);
      case ($urandom_range(0, 3))
        0: sh = 13'($urandom());
        1: sh = 13'h1000;
        default: begin
          k  = int'($urandom_range(0, 140)) - 70;
          sh = k[12:0];
        end
      endcase
      step($urandom_range(0, 3) != 0, r64[57:0], 13'($urandom()),
           sh, 1'($urandom()), 1'($urandom()),
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
